// File: rtl/qei_pkg.sv
// rtl/qei_pkg.sv - shared widths, channel-state encodings and step decoder for the quadrature encoder interface
//
// Contents:
//   COUNT_W      width of the position counter
//   SYNC_STAGES  flops in each channel synchronizer
//   FILTER_LEN   consecutive identical samples needed by the optional glitch filter
//   UIO_OE_ALL   output-enable pattern for the bidirectional pins
//   qei_state_t  {A,B} channel states S00/S01/S11/S10
//   qei_step_t   decoded motion for one cycle
//   qei_decode   maps (previous, current) channel state to a step

package qei_pkg;

    localparam int COUNT_W     = 16;
    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 3;

    localparam logic [7:0] UIO_OE_ALL = 8'hFF;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } qei_state_t;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_FWD  = 2'b01,
        STEP_REV  = 2'b10
    } qei_step_t;

    // Gray-code walk: forward is 00->01->11->10->00, reverse is the opposite
    // direction. Equal states and two-bit jumps both decode as no motion.
    function automatic qei_step_t qei_decode(input qei_state_t prev, input qei_state_t cur);
        qei_step_t step;
        step = STEP_NONE;
        case ({prev, cur})
            {S00, S01}, {S01, S11}, {S11, S10}, {S10, S00}: step = STEP_FWD;
            {S00, S10}, {S10, S11}, {S11, S01}, {S01, S00}: step = STEP_REV;
            default:                                        step = STEP_NONE;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/qei_sync.sv
// rtl/qei_sync.sv - per-channel input synchronizer with optional glitch filter
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset, clears every stage to 0
//   din    raw encoder channel pin
//   dout   synchronized (and, with QEI_GLITCH_FILTER_EN, filtered) channel level
//
// Configuration:
//   QEI_GLITCH_FILTER_EN  when defined, dout only follows the synchronized level
//                         after FILTER_LEN consecutive identical samples, which
//                         adds FILTER_LEN cycles of latency.

module qei_sync
    import qei_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

`ifdef QEI_GLITCH_FILTER_EN

    // window holds the newest synchronized sample plus the FILTER_LEN-1 before it.
    logic [FILTER_LEN-2:0] hist_q;
    logic [FILTER_LEN-1:0] window;
    logic                  filt_q;

    assign window = {hist_q, sync_q[SYNC_STAGES-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= window[FILTER_LEN-2:0];
            if (&window) begin
                filt_q <= 1'b1;
            end else if (~|window) begin
                filt_q <= 1'b0;
            end
        end
    end

    assign dout = filt_q;

`else

    assign dout = sync_q[SYNC_STAGES-1];

`endif

endmodule

// File: rtl/tt_um_jakedrew_qei.sv
// rtl/tt_um_jakedrew_qei.sv - x4 quadrature encoder decoder with 16-bit position counter
//
// Ports:
//   ui_in[0]    encoder channel A
//   ui_in[1]    encoder channel B (ui_in[7:2] unused)
//   uo_out      {DIR, count[6:0]}, registered
//   uio_in      unused
//   uio_out     count[14:7], registered (count[15] is internal only)
//   uio_oe      constant 8'hFF
//   ena         ignored, block is always active
//   clk         system clock
//   rst_n       asynchronous active-low reset
//
// Configuration:
//   QEI_GLITCH_FILTER_EN  enables the per-channel glitch filter inside qei_sync.
//
// Pin-to-output latency: 2 sync + 1 decode/count + 1 output register = 4 cycles
// (7 with the glitch filter).

module tt_um_jakedrew_qei
    import qei_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic               a_s;
    logic               b_s;
    qei_state_t         cur_ab;
    qei_state_t         prev_ab;
    qei_step_t          step;
    logic [COUNT_W-1:0] count;
    logic               dir;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:2]};

    qei_sync u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ui_in[0]),
        .dout  (a_s)
    );

    qei_sync u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ui_in[1]),
        .dout  (b_s)
    );

    assign cur_ab = qei_state_t'({a_s, b_s});

    // Resetting prev_ab to S00 means the first decode after release compares
    // against 00; a non-idle pin state at release yields one spurious step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ab <= S00;
        end else begin
            prev_ab <= cur_ab;
        end
    end

    assign step = qei_decode(prev_ab, cur_ab);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            dir   <= 1'b0;
        end else begin
            case (step)
                STEP_FWD: begin
                    count <= count + COUNT_W'(1);
                    dir   <= 1'b1;
                end
                STEP_REV: begin
                    count <= count - COUNT_W'(1);
                    dir   <= 1'b0;
                end
                default: begin
                    count <= count;
                    dir   <= dir;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_out  <= 8'h00;
            uio_out <= 8'h00;
        end else begin
            uo_out  <= {dir, count[6:0]};
            uio_out <= count[14:7];
        end
    end

    assign uio_oe = UIO_OE_ALL;

endmodule

// File: tb/tb_tt_um_jakedrew_qei.sv
// tb/tb_tt_um_jakedrew_qei.sv - scoreboard testbench for tt_um_jakedrew_qei

`timescale 1ns/1ps

module tb_tt_um_jakedrew_qei;

`ifdef QEI_GLITCH_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 4;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        string      name;
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    tt_um_jakedrew_qei dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({uo_out, uio_out, uio_oe} !== {e.uo, e.uio, 8'hFF}) begin
                    errors++;
                    $display("FAIL %s: got uo_out=%h uio_out=%h uio_oe=%h, expected uo_out=%h uio_out=%h uio_oe=ff",
                             e.name, uo_out, uio_out, uio_oe, e.uo, e.uio);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input string name, input logic [7:0] uo, input logic [7:0] uio);
        exp_t e;
        e.name = name;
        e.uo   = uo;
        e.uio  = uio;
        sb.push_back(e);
    endtask

    // Outputs are checked 1 ns after the last waited rising edge.
    task automatic expect_now(input string name, input logic [7:0] uo, input logic [7:0] uio);
        #1;
        push_exp(name, uo, uio);
    endtask

    // ab is the {A,B} state; A is ui_in[0], B is ui_in[1].
    task automatic drive(input logic [1:0] ab, input int hold);
        @(negedge clk);
        ui_in = {6'b0, ab[0], ab[1]};
        repeat (hold) @(posedge clk);
    endtask

    task automatic fwd_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(2'b01, 16);
            drive(2'b11, 16);
            drive(2'b10, 16);
            drive(2'b00, 16);
        end
    endtask

    task automatic rev_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(2'b10, 16);
            drive(2'b11, 16);
            drive(2'b01, 16);
            drive(2'b00, 16);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        repeat (3) @(posedge clk);
        expect_now("reset", 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (32) @(posedge clk);
        expect_now("idle_32", 8'h00, 8'h00);

        // First forward step must be visible within LAT cycles: count 1, DIR 1.
        drive(2'b01, LAT);
        expect_now("latency", 8'h81, 8'h00);
        repeat (16 - LAT) @(posedge clk);
        drive(2'b11, 16);
        drive(2'b10, 16);
        drive(2'b00, 16);
        expect_now("fwd_1cycle", 8'h84, 8'h00);          // count 4

        fwd_cycles(8);
        expect_now("fwd_8", 8'hA4, 8'h00);               // count 36 = 0x24

        fwd_cycles(64);
        expect_now("fwd_64", 8'hA4, 8'h02);              // count 292 = 0x124

        rev_cycles(64);
        expect_now("rev_64", 8'h24, 8'h00);              // count 36, DIR 0

        rev_cycles(9);
        expect_now("rev_to_zero", 8'h00, 8'h00);         // count 0

        drive(2'b10, 16);
        expect_now("wrap_down", 8'h7F, 8'hFF);           // count 0xFFFF, pins 0x7FFF

        drive(2'b00, 16);
        expect_now("wrap_up", 8'h80, 8'h00);             // count 0, DIR 1

        drive(2'b11, 16);
        expect_now("illegal_00_11", 8'h80, 8'h00);
        drive(2'b00, 16);
        expect_now("illegal_11_00", 8'h80, 8'h00);

`ifdef QEI_GLITCH_FILTER_EN
        drive(2'b10, 1);
        drive(2'b00, 16);
        expect_now("glitch_a", 8'h80, 8'h00);
`endif

        fwd_cycles(1);
        expect_now("pre_reset", 8'h84, 8'h00);           // count 4

        // Reset mid-motion with pins at 01: clears at once, then one spurious
        // forward step is decoded against the reset state 00.
        drive(2'b01, 0);
        @(negedge clk);
        rst_n = 1'b0;
        expect_now("mid_reset", 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(posedge clk);
        expect_now("spurious_step", 8'h81, 8'h00);       // count 1, DIR 1

        drive(2'b11, 16);
        drive(2'b10, 16);
        drive(2'b00, 16);
        expect_now("post_reset_fwd", 8'h84, 8'h00);      // count 4

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries never checked, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_jakedrew_qei.md
TT_UM_JAKEDREW_QEI -- requirements
Module: tt_um_jakedrew_qei

Interface
REQ-001: clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-002: rst_n  input  1  asynchronous, active-low reset.
REQ-003: ena  input  1  design-enable strobe; SHALL be ignored (block always active).
REQ-004: ui_in  input  8  bit0 = encoder channel A, bit1 = channel B, bits7:2 unused.
REQ-005: uo_out  output  8  bits6:0 = count[6:0], bit7 = DIR.
REQ-006: uio_in  input  8  unused.
REQ-007: uio_out  output  8  count[14:7].
REQ-008: uio_oe  output  8  SHALL be constant 8'hFF (all uio pins driven as outputs).

Function
REQ-009: A and B SHALL each pass through a 2-flop synchronizer before decoding.
REQ-010: A decoder SHALL keep the previous synchronized state {A,B} and compare it with the current one every cycle (x4 decoding: every valid edge counts).
REQ-011: Forward transitions {A,B}: 00->01, 01->11, 11->10, 10->00; each SHALL increment count by 1.
REQ-012: Reverse transitions: 00->10, 10->11, 11->01, 01->00; each SHALL decrement count by 1.
REQ-013: No change, or a change of both bits in one cycle (illegal), SHALL leave count and DIR unchanged.
REQ-014: count SHALL be a 16-bit register named count, wrapping modulo 2^16 in both directions (0xFFFF+1 = 0x0000, 0x0000-1 = 0xFFFF).
REQ-015: DIR SHALL be 1 after a forward step and 0 after a reverse step; it holds its value otherwise.
REQ-016: count SHALL be visible on uo_out/uio_out no more than 4 clk cycles after a pin change (sync 2 + decode/update 1 + output registered).
REQ-017: count[15] SHALL not appear on any pin; the pin-visible value is count[14:0].
REQ-018: Outputs SHALL be driven from registers (no combinational path from ui_in to outputs).

Reset
REQ-019: While rst_n=0: count = 0, DIR = 0, synchronizer and previous-state flops = 0, uo_out = 8'h00, uio_out = 8'h00; uio_oe stays 8'hFF.
REQ-020: Reset asserted mid-motion SHALL clear immediately; after release, the first decode SHALL compare against state 00. If the pins are not at 00, one spurious step is therefore possible, and this is acceptable.

Configuration
REQ-021: Macro QEI_GLITCH_FILTER_EN. When defined, each synchronized channel SHALL pass through a filter that updates only after 3 consecutive identical samples, adding 3 cycles of latency (total ≤ 7 cycles). When undefined, there is no filter and the latency of REQ-016 applies.

Structure
REQ-022: Package qei_pkg SHALL hold COUNT_W = 16, SYNC_STAGES = 2, FILTER_LEN = 3, and the 2-bit state encodings (S00, S01, S11, S10).
REQ-023: Sub-module qei_sync (synchronizer plus optional filter, per channel) SHALL be instantiated twice; decoding and counting stay in the top module.

Verification
REQ-024: Reset, then hold A=B=0 for 32 cycles -> count=0, uo_out=0x00, uio_out=0x00, uio_oe=0xFF.
REQ-025: 8 forward cycles (01,11,10,00; each held 16 clk) -> uo_out[6:0] delta = 32 (mod 128), DIR=1.
REQ-026: 64 forward cycles -> count delta = +256, i.e. {uio_out, uo_out[6:0]} increases by 256.
REQ-027: 64 reverse cycles (10,11,01,00) -> count delta = -256, DIR=0.
REQ-028: From count=0, one reverse step -> count=0xFFFF, pin value 0x7FFF. Then one forward step -> count=0.
REQ-029: Illegal jump 00->11 held 16 clk -> count and DIR unchanged. Under QEI_GLITCH_FILTER_EN, a 1-cycle pulse on A -> count unchanged.
